// File: rtl/counter_capture_pkg.sv
// Shared event codes and entry-width helper for the counter event capture block.
// Pure declarations: no logic, no latency, no flow control.
// Imported by the capture top level and its testbench.
package counter_capture_pkg;

    localparam logic [1:0] EV_CROSS_UP = 2'd0;
    localparam logic [1:0] EV_CROSS_DN = 2'd1;
    localparam logic [1:0] EV_WRAP_UP  = 2'd2;
    localparam logic [1:0] EV_WRAP_DN  = 2'd3;

    // Entry layout is {value, code, timestamp}, MSB first.
    function automatic int entry_w(input int data_w, input int ts_w);
        return data_w + 2 + ts_w;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous show-ahead FIFO: the head entry is on dout whenever valid is high.
// Latency: a push is visible one cycle later; a pop exposes the next entry one cycle later.
// Backpressure: a push while full is taken only with a same-cycle pop; pop while empty is ignored.
module capture_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     SCLR,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    assign do_rd = pop && valid;
    // When full, the slot being written is the one the same-cycle pop frees.
    assign do_wr = push && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (SCLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/counter_event_capture.sv
// Detects threshold crossings and wraps of Q, timestamps them and queues them in a FIFO.
// Latency: an event detected on an edge is on ev_valid/ev_data the following cycle.
// Backpressure: ev_ready pops the head; events arriving with a full, non-popping buffer are dropped into sticky overflow.
module counter_event_capture
    import counter_capture_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16
) (
    input  logic                     clk,
    input  logic                     SCLR,
    input  logic [DATA_W-1:0]        Q,
    input  logic [DATA_W-1:0]        THRESH,
    input  logic                     ARM,
    output logic                     armed,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [DATA_W-1:0]        ev_data,
    output logic [1:0]               ev_code,
    output logic [TS_W-1:0]          ev_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int EW = entry_w(DATA_W, TS_W);

    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] q_d;
    logic              hit;
    logic [1:0]        code;
    logic [EW-1:0]     fifo_dout;
    logic              fifo_full;

    always_ff @(posedge clk) begin
        if (SCLR) ts <= '0;
        else      ts <= ts + 1'b1;
    end

    // The first ARM cycle only loads q_d; detection needs a valid previous sample.
    always_ff @(posedge clk) begin
        if (SCLR) begin
            armed <= 1'b0;
            q_d   <= '0;
        end else if (!ARM) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            q_d   <= Q;
        end
    end

    // Wraps are tested first so they mask the crossing they imply.
    always_comb begin
        hit  = 1'b0;
        code = EV_CROSS_UP;
        if (armed && ARM) begin
            if (q_d == '1 && Q == '0) begin
                hit  = 1'b1;
                code = EV_WRAP_UP;
            end else if (q_d == '0 && Q == '1) begin
                hit  = 1'b1;
                code = EV_WRAP_DN;
            end else if (q_d < THRESH && Q >= THRESH) begin
                hit  = 1'b1;
                code = EV_CROSS_UP;
            end else if (q_d >= THRESH && Q < THRESH) begin
                hit  = 1'b1;
                code = EV_CROSS_DN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (SCLR)                                          overflow <= 1'b0;
        else if (hit && fifo_full && !(ev_valid && ev_ready)) overflow <= 1'b1;
    end

    capture_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .SCLR  (SCLR),
        .push  (hit),
        .din   ({Q, code, ts}),
        .pop   (ev_ready),
        .dout  (fifo_dout),
        .valid (ev_valid),
        .count (count),
        .full  (fifo_full)
    );

    assign ev_data = fifo_dout[EW-1 -: DATA_W];
    assign ev_code = fifo_dout[TS_W +: 2];
    assign ev_ts   = fifo_dout[TS_W-1:0];

endmodule
